banco_registradores: RTL and testbench

BANCO_REGISTRADORES -- requirements
Module: banco_registradores

---
 rtl/banco_registradores_pkg.sv | 11 +
 rtl/banco_registradores_if.sv | 24 ++
 rtl/banco_dump_fsm.sv | 36 +++
 rtl/banco_registradores.sv | 41 ++++
 tb/tb_banco_registradores.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/banco_registradores_pkg.sv
// banco_registradores_pkg: register-file constants and dump FSM state encoding
package banco_registradores_pkg;
  localparam int NUM_REGS = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_KERNEL_ADDR = 5'd25;
  localparam logic [4:0] REG_SP = 5'd29;
  localparam logic [4:0] REG_ADDRESS = 5'd31;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
endpackage

// File: rtl/banco_registradores_if.sv
// banco_registradores_if: read/write ports and debug dump stream of the register file
interface banco_registradores_if #(parameter int DATA_W = 32);
  logic [4:0] RS;
  logic [4:0] RT;
  logic [4:0] regEscrito;
  logic [DATA_W-1:0] dadoEscrito;
  logic escreveReg;
  logic [DATA_W-1:0] dadoRS;
  logic [DATA_W-1:0] dadoRT;
  logic dump_start;
  logic dump_valid;
  logic dump_ready;
  logic [4:0] dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic dump_busy;
  modport master (
    output RS, RT, regEscrito, dadoEscrito, escreveReg, dump_start, dump_ready,
    input dadoRS, dadoRT, dump_valid, dump_idx, dump_data, dump_busy
  );
  modport slave (
    input RS, RT, regEscrito, dadoEscrito, escreveReg, dump_start, dump_ready,
    output dadoRS, dadoRT, dump_valid, dump_idx, dump_data, dump_busy
  );
endinterface

// File: rtl/banco_dump_fsm.sv
// banco_dump_fsm: walks all registers, one LOAD + SEND beat per index, ready/valid handshake
module banco_dump_fsm
  import banco_registradores_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_start,
  input  logic              dump_ready,
  input  logic [DATA_W-1:0] rd_data,
  output logic [4:0]        dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_valid,
  output logic              dump_busy
);
  logic [1:0] state;
  // index wraps 31 -> 0 naturally on the final accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      dump_idx <= '0;
      dump_data <= '0;
    end else if (state == ST_IDLE) begin
      if (dump_start) state <= ST_LOAD;
    end else if (state == ST_LOAD) begin
      dump_data <= rd_data;
      state <= ST_SEND;
    end else if (dump_ready) begin
      state <= (dump_idx == REG_ADDRESS) ? ST_IDLE : ST_LOAD;
      dump_idx <= dump_idx + 5'd1;
    end
  end
  assign dump_valid = state == ST_SEND;
  assign dump_busy = state != ST_IDLE;
endmodule

// File: rtl/banco_registradores.sv
// banco_registradores: 32-entry register file, 2 combinational read ports with write bypass,
// plus a debug dump stream of every register
module banco_registradores
  import banco_registradores_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter logic [31:0] SP_INIT = 32'h0000_3FFC
) (
  input logic                  clk,
  input logic                  rst_n,
  banco_registradores_if.slave bus
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] dump_rd;
  logic wr_en;
  assign wr_en = bus.escreveReg && bus.regEscrito != REG_ZERO;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= (i == int'(REG_SP)) ? DATA_W'(SP_INIT) : '0;
    end else if (wr_en) begin
      regs[bus.regEscrito] <= bus.dadoEscrito;
    end
  end
  // a same-cycle write to the addressed register is forwarded to the reader
  always_comb begin
    bus.dadoRS = (bus.RS == REG_ZERO) ? '0 : (wr_en && bus.regEscrito == bus.RS) ? bus.dadoEscrito : regs[bus.RS];
    bus.dadoRT = (bus.RT == REG_ZERO) ? '0 : (wr_en && bus.regEscrito == bus.RT) ? bus.dadoEscrito : regs[bus.RT];
    dump_rd = (bus.dump_idx == REG_ZERO) ? '0 : (wr_en && bus.regEscrito == bus.dump_idx) ? bus.dadoEscrito : regs[bus.dump_idx];
  end
  banco_dump_fsm #(.DATA_W(DATA_W)) u_dump (
    .clk(clk),
    .rst_n(rst_n),
    .dump_start(bus.dump_start),
    .dump_ready(bus.dump_ready),
    .rd_data(dump_rd),
    .dump_idx(bus.dump_idx),
    .dump_data(bus.dump_data),
    .dump_valid(bus.dump_valid),
    .dump_busy(bus.dump_busy)
  );
endmodule

// File: tb/tb_banco_registradores.sv
// tb_banco_registradores: random and directed checks against an array model of the register file
module tb_banco_registradores;
  localparam logic [31:0] SP = 32'h0000_3FFC;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [31:0] m [32];
  logic [31:0] prev_view [32];
  logic [31:0] seen [32];
  logic we_d;
  logic [4:0] wa_d;
  logic [31:0] wd_d;
  logic [4:0] exp_idx;
  logic new_beat;
  logic [31:0] beat_data;
  logic last_busy;
  int beats;
  int n;
  banco_registradores_if #(.DATA_W(32)) bus();
  banco_registradores #(.DATA_W(32), .SP_INIT(SP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // what a reader of address a sees this cycle: reg 0 is 0, a pending write wins, else stored value
  function automatic logic [31:0] view(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : (we_d && wa_d != 5'd0 && wa_d == a) ? wd_d : m[a];
  endfunction
  task automatic model_reset();
    foreach (m[i]) m[i] = 32'd0;
    m[29] = SP;
    exp_idx = 5'd0;
    new_beat = 1'b1;
  endtask
  // one clock cycle, entered and left just after a falling edge
  task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wa,
                     input logic [31:0] wd, input logic we, input logic st, input logic rdy);
    bus.RS = rs; bus.RT = rt; bus.regEscrito = wa; bus.dadoEscrito = wd;
    bus.escreveReg = we; bus.dump_start = st; bus.dump_ready = rdy;
    we_d = we; wa_d = wa; wd_d = wd;
    #1;
    chk("dadoRS", bus.dadoRS, view(rs));
    chk("dadoRT", bus.dadoRT, view(rt));
    chk("valid_without_busy", {31'd0, bus.dump_valid & ~bus.dump_busy}, 32'd0);
    last_busy = bus.dump_busy;
    if (bus.dump_valid) begin
      if (new_beat) begin
        // a beat carries what its LOAD cycle (the previous cycle) would have read
        beat_data = prev_view[exp_idx];
        seen[exp_idx] = bus.dump_data;
      end
      chk(new_beat ? "beat_idx" : "hold_idx", {27'd0, bus.dump_idx}, {27'd0, exp_idx});
      chk(new_beat ? "beat_data" : "hold_data", bus.dump_data, beat_data);
      new_beat = rdy;
      if (rdy) begin
        beats++;
        exp_idx = exp_idx + 5'd1;
      end
    end
    for (int i = 0; i < 32; i++) prev_view[i] = view(5'(i));
    @(posedge clk);
    if (we && wa != 5'd0) m[wa] = wd;
    @(negedge clk);
  endtask
  initial begin
    bus.RS = '0; bus.RT = '0; bus.regEscrito = '0; bus.dadoEscrito = '0;
    bus.escreveReg = 1'b1; bus.dump_start = 1'b0; bus.dump_ready = 1'b0;
    we_d = 1'b0; wa_d = '0; wd_d = '0; beats = 0; last_busy = 1'b0;
    foreach (seen[i]) seen[i] = 32'd0;
    foreach (prev_view[i]) prev_view[i] = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, bus.dump_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.dump_busy}, 32'd0);
    chk("rst_idx", {27'd0, bus.dump_idx}, 32'd0);
    chk("rst_data", bus.dump_data, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) cyc(5'(i), 5'(31 - i), 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("sp_reset", m[29], SP);
    cyc(5'd5, 5'd5, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    cyc(5'd5, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    cyc(5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    cyc(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    cyc(5'd0, 5'd0, 5'd31, 32'hA5A5_0031, 1'b1, 1'b0, 1'b0);
    cyc(5'd0, 5'd0, 5'd25, 32'h5A5A_0025, 1'b1, 1'b0, 1'b0);
    cyc(5'd31, 5'd25, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    // full dump of regs[i] = i*4 with ready held high
    for (int i = 1; i < 32; i++) cyc(5'(i), 5'(i), 5'(i), 32'(i * 4), 1'b1, 1'b0, 1'b0);
    beats = 0;
    cyc(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    n = 0;
    do begin
      cyc(5'($urandom), 5'($urandom), 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      n++;
    end while (last_busy && n < 100);
    chk("dump_len", 32'(n - 1), 32'd64);
    chk("dump_beats", 32'(beats), 32'd32);
    for (int i = 0; i < 32; i++) chk("beat_i4", seen[i], 32'(i * 4));
    // stall at idx 3 with writes, then reset at idx 12
    cyc(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    n = 0;
    while (exp_idx != 5'd3 && n < 100) begin cyc(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1); n++; end
    chk("reach_idx3", {31'd0, n < 100}, 32'd1);
    cyc(5'd3, 5'd10, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      cyc(5'd3, 5'd10, (k == 1) ? 5'd10 : 5'd3, (k == 1) ? 32'h1234_5678 : 32'hBAD0_0000 + 32'(k), 1'b1, 1'b0, 1'b0);
    n = 0;
    while (exp_idx != 5'd12 && n < 100) begin cyc(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1); n++; end
    chk("reach_idx12", {31'd0, n < 100}, 32'd1);
    chk("beat3_old", seen[3], 32'd12);
    chk("beat10_new", seen[10], 32'h1234_5678);
    cyc(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_valid", {31'd0, bus.dump_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, bus.dump_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, bus.dump_busy}, 32'd0);
    chk("rst_mid_idx", {27'd0, bus.dump_idx}, 32'd0);
    chk("rst_mid_data", bus.dump_data, 32'd0);
    bus.escreveReg = 1'b1; bus.regEscrito = 5'd7; bus.dadoEscrito = 32'hFFFF_0007;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc(5'd7, 5'd29, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(5'd3, 5'd10, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("no_beat_after_rst", {31'd0, bus.dump_valid | bus.dump_busy}, 32'd0);
    end
    // restarted dump with random ready and random writes
    beats = 0;
    cyc(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    n = 0;
    do begin
      cyc(5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      n++;
    end while (last_busy && n < 1000);
    chk("restart_beats", 32'(beats), 32'd32);
    for (int k = 0; k < 400; k++)
      cyc(5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'($urandom), ($urandom % 20) == 0, 1'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
